// File: rtl/sigma_delta_i2s_tx.sv
// rtl/sigma_delta_i2s_tx.sv - sample FIFO plus I2S master serialiser for decimated ADC samples
// Define SIGMA_DELTA_I2S_LEFT_JUSTIFIED_EN for left-justified framing (no 1-BCLK data delay).
module sigma_delta_i2s_tx #(
    parameter int SAMPLE_BITLEN = 24,
    parameter int SLOT_BITLEN   = 32,
    parameter int CLK_PER_BCLK  = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SAMPLE_BITLEN-1:0]      sample_in,
    input  logic                          sample_valid,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int DIV_W = $clog2(CLK_PER_BCLK);
    localparam int BIT_W = $clog2(2 * SLOT_BITLEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BCLK - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_PER_BCLK / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITLEN - 1);
    localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_BITLEN);
    localparam logic [BIT_W-1:0] SAMPLE_C = BIT_W'(SAMPLE_BITLEN);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [SAMPLE_BITLEN-1:0] MSB_MASK = {1'b1, {(SAMPLE_BITLEN-1){1'b0}}};

    logic [DIV_W-1:0]         r_div_cnt;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic                     r_bclk;
    logic                     r_lrclk;
    logic                     r_sdata;
    logic [SAMPLE_BITLEN-1:0] r_tx_word;
    logic [SAMPLE_BITLEN-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_fall;
    logic                     w_frame_start;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [BIT_W-1:0]         w_bit_next;
    logic                     w_lr_next;
    logic [BIT_W-1:0]         w_k;
    logic [BIT_W-1:0]         w_shamt;
    logic [SAMPLE_BITLEN-1:0] w_word_next;
    logic                     w_sdata_next;

    assign w_fall        = (r_div_cnt == DIV_LAST);
    assign w_frame_start = w_fall && (r_bit_cnt == BIT_LAST);
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CNT_FULL);
    // A pop at frame start frees a slot in the same clk, so a full FIFO still accepts the write.
    assign w_pop         = w_frame_start && !w_empty;
    assign w_push        = sample_valid && (!w_full || w_pop);
    assign w_drop        = sample_valid && w_full && !w_pop;

    assign w_bit_next    = w_frame_start ? '0 : (r_bit_cnt + BIT_ONE);
    assign w_lr_next     = (w_bit_next >= SLOT_C);
    assign w_k           = w_lr_next ? (w_bit_next - SLOT_C) : w_bit_next;
    assign w_word_next   = w_pop ? r_mem[r_rd_ptr] : r_tx_word;

    always_comb begin
        w_sdata_next = 1'b0;
        w_shamt      = '0;
`ifdef SIGMA_DELTA_I2S_LEFT_JUSTIFIED_EN
        if (w_k < SAMPLE_C) begin
            w_shamt      = w_k;
            w_sdata_next = |(w_word_next & (MSB_MASK >> w_shamt));
        end
`else
        if ((w_k != '0) && (w_k <= SAMPLE_C)) begin
            w_shamt      = w_k - BIT_ONE;
            w_sdata_next = |(w_word_next & (MSB_MASK >> w_shamt));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_bclk      <= 1'b0;
            r_bit_cnt   <= '0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_tx_word   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_div_cnt   <= w_fall ? '0 : (r_div_cnt + DIV_ONE);
            r_bclk      <= (r_div_cnt >= DIV_HALF);
            r_underflow <= w_frame_start && w_empty;
            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                r_lrclk   <= w_lr_next;
                r_sdata   <= w_sdata_next;
                r_tx_word <= w_word_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_sdata  = r_sdata;
    assign fifo_level = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_sigma_delta_i2s_tx.sv
// tb/tb_sigma_delta_i2s_tx.sv - scoreboard bench for sigma_delta_i2s_tx framing, FIFO and reset
module tb_sigma_delta_i2s_tx;

    localparam int SB    = 24;
    localparam int SLOT  = 32;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NBITS = 2 * SLOT;
    localparam int FRAME = CPB * NBITS;
`ifdef SIGMA_DELTA_I2S_LEFT_JUSTIFIED_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SB-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          underflow;

    sigma_delta_i2s_tx #(
        .SAMPLE_BITLEN (SB),
        .SLOT_BITLEN   (SLOT),
        .CLK_PER_BCLK  (CPB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; frame j starts when tb_cyc == j*FRAME.
    int tb_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    int total = 0;
    int bad = 0;
    int uf_total = 0;
    int ov_total = 0;
    logic [SB-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    logic [NBITS-1:0] m_bits;
    logic             m_uf;
    logic [SB-1:0]    m_last;
    int               m_errs;

    always @(negedge clk) begin : monitor
        int c;
        int b;
        int fr;
        int pad;
        logic exp_bclk;
        logic [SB-1:0] exp_w;
        logic [SB-1:0] lw;
        logic [SB-1:0] rw;
        if (!rst_n) begin
            m_errs = 0;
            m_last = '0;
            m_uf   = 1'b0;
        end else begin
            c = tb_cyc;
            exp_bclk = (c >= 1) && (((c - 1) % CPB) >= CPB / 2);
            if (i2s_bclk !== exp_bclk) m_errs++;
            if (overflow === 1'b1) ov_total++;
            if (underflow === 1'b1) begin
                uf_total++;
                if (c % FRAME != 0) m_errs++;
            end
            if (c % FRAME == 0) m_uf = (underflow === 1'b1);
            if (c % CPB == CPB - 1) begin
                b  = (c / CPB) % NBITS;
                fr = c / FRAME;
                if (i2s_lrclk !== (b >= SLOT)) m_errs++;
                m_bits[b] = i2s_sdata;
                if (b == NBITS - 1) begin
                    if (fr == 0) begin
                        exp_w = '0;
                    end else if (m_uf) begin
                        exp_w = m_last;
                    end else begin
                        chk("pop_expected", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
                        else                  exp_w = m_last;
                    end
                    m_last = exp_w;
                    lw  = '0;
                    rw  = '0;
                    pad = 0;
                    for (int i = 0; i < SLOT; i++) begin
                        if (i >= OFF && i < OFF + SB) begin
                            lw[SB-1-(i-OFF)] = m_bits[i];
                            rw[SB-1-(i-OFF)] = m_bits[SLOT+i];
                        end else begin
                            pad += int'(m_bits[i]) + int'(m_bits[SLOT+i]);
                        end
                    end
                    chk("left_word", 32'(lw), 32'(exp_w));
                    chk("right_word", 32'(rw), 32'(exp_w));
                    chk("pad_bits", pad, 0);
                    chk("frame_timing", m_errs, 0);
                    m_errs = 0;
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (tb_cyc < c) @(negedge clk);
    endtask

    task automatic push(input logic [SB-1:0] d, input bit kept);
        sample_in    = d;
        sample_valid = 1'b1;
        if (kept) exp_q.push_back(d);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_bclk", 32'(i2s_bclk), 32'd0);
        chk("rst_lrclk", 32'(i2s_lrclk), 32'd0);
        chk("rst_sdata", 32'(i2s_sdata), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int uf0;
        int ov0;
        @(negedge clk);
        do_reset();

        // Idle frames, then a single sample that keeps repeating on underflow.
        wait_until(FRAME * 3 - 100);
        push(24'h123456, 1'b1);
        wait_until(FRAME * 5 + 128);
        chk("uf_count_idle", uf_total, 4);
        push(24'hA5C3F0, 1'b1);
        wait_until(FRAME * 6 + 128);
        push(24'h800000, 1'b1);
        wait_until(FRAME * 7 + 128);
        push(24'h7FFFFF, 1'b1);
        wait_until(FRAME * 9 - 2);
        push(24'h0F0F0F, 1'b1);
        wait_until(FRAME * 10 - 1);
        push(24'h3C3C3C, 1'b1);
        wait_until(FRAME * 12 + 4);
        chk("uf_count_run", uf_total, 6);
        chk("ov_count_run", ov_total, 0);
        chk("queue_drained_1", exp_q.size(), 0);

        // Back-to-back writes straight after reset: fifth one overflows.
        do_reset();
        uf0 = uf_total;
        ov0 = ov_total;
        push(24'h111111, 1'b1);
        push(24'h222222, 1'b1);
        push(24'h333333, 1'b1);
        push(24'h444444, 1'b1);
        push(24'h555555, 1'b0);
        wait_until(10);
        chk("level_full", 32'(fifo_level), 32'd4);
        chk("overflow_once", ov_total - ov0, 1);
        wait_until(300);
        chk("level_after_pop", 32'(fifo_level), 32'd3);
        wait_until(FRAME * 5 + 10);
        chk("uf_after_burst", uf_total - uf0, 1);
        push(24'hAAAAAA, 1'b1);
        push(24'h555555, 1'b1);

        // Reset mid right slot with two samples queued.
        wait_until(FRAME * 5 + CPB * 40 + 1);
        chk("level_two_queued", 32'(fifo_level), 32'd2);
        chk("lrclk_before_rst", 32'(i2s_lrclk), 32'd1);
        do_reset();
        uf0 = uf_total;
        wait_until(FRAME + 4);
        chk("uf_first_frame", uf_total - uf0, 1);
        wait_until(2 * FRAME + 4);
        chk("uf_second_frame", uf_total - uf0, 2);
        chk("queue_drained_2", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sigma_delta_i2s_tx.md
Name: sigma_delta_i2s_tx

Overview:
- Downstream consumer of sigma_delta_adc: takes decimated `adc_output`/`adc_valid` samples and transmits them as an I2S master stream (BCLK, LRCLK, SDATA) to an external codec, DSP or logic analyser.
- A small FIFO absorbs jitter between the ADC sample rate and the I2S frame rate.
- The mono ADC sample goes out identically on the left and right slots of each frame.

Parameters:
- SAMPLE_BITLEN, 24, width of `sample_in`; equals the ADC's ADC_BITLEN.
- SLOT_BITLEN, 32, BCLK periods per channel slot; must be >= SAMPLE_BITLEN+1.
- CLK_PER_BCLK, 4, clk cycles per BCLK period; even, >= 2.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, >= 2.

Ports:
- clk, in, 1, system clock; same domain as sigma_delta_adc.
- rst_n, in, 1, asynchronous active-low reset.
- sample_in, in, SAMPLE_BITLEN, ADC sample, two's complement or unsigned (passed through unchanged).
- sample_valid, in, 1, one write per clk cycle in which it is high.
- i2s_bclk, out, 1, bit clock.
- i2s_lrclk, out, 1, word select: 0 = left slot, 1 = right slot.
- i2s_sdata, out, 1, serial data, MSB first.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- overflow, out, 1, one-clk pulse when a write is dropped.
- underflow, out, 1, one-clk pulse when a frame starts with the FIFO empty.

Behaviour:
- Reset (async assert, sync-released internally by logic design, not a synchronizer):
  - All outputs are 0: i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underflow.
  - FIFO is empty; held word tx_word = 0; div_cnt = 0; bit_cnt = 0.
- Divider:
  - div_cnt counts 0..CLK_PER_BCLK-1 and wraps.
  - Registered i2s_bclk is 1 while div_cnt >= CLK_PER_BCLK/2 and lags div_cnt by 1 clk.
  - A "fall" event occurs when div_cnt wraps to 0. All serial outputs change only on fall events.
- Frame:
  - bit_cnt counts 0..2*SLOT_BITLEN-1 and advances on each fall event.
  - i2s_lrclk = (bit_cnt >= SLOT_BITLEN).
  - k = bit_cnt mod SLOT_BITLEN.
  - Standard I2S with 1-BCLK delay: sdata = tx_word[SAMPLE_BITLEN-k] for k = 1..SAMPLE_BITLEN; sdata = 0 for k = 0 and for k > SAMPLE_BITLEN.
- Frame start (fall event with bit_cnt wrapping to 0):
  - FIFO non-empty: pop the head into tx_word.
  - FIFO empty: tx_word holds its previous value and underflow pulses for 1 clk.
  - Both slots of the frame use the same tx_word.
- FIFO write:
  - sample_valid=1 and not full: push.
  - sample_valid=1 and full: drop the sample, FIFO unchanged, overflow pulses for 1 clk.
  - Push and pop in the same clk while full: pop takes effect first, push is accepted, level is unchanged, no overflow.
  - Push and pop in the same clk while empty: the pop sees empty (underflow) and the push is stored.
- fifo_level is registered and updates 1 clk after the push/pop.
- Latency: a sample pushed into an empty FIFO at least 1 clk before a frame-start fall event appears with its MSB at bit_cnt=1 of that frame.
- Pointers wrap modulo FIFO_DEPTH. Full/empty status is derived from a count register, never from pointer equality alone.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, the first frame starts at bit_cnt=0 with an empty FIFO.

Optional Feature:
- Macro: SIGMA_DELTA_I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format, no 1-BCLK delay. sdata = tx_word[SAMPLE_BITLEN-1-k] for k = 0..SAMPLE_BITLEN-1, else 0. Legal with SLOT_BITLEN >= SAMPLE_BITLEN.
- Undefined: standard I2S as specified in Behaviour.
- LRCLK timing is identical in both modes.

Test Plan (defaults; frame = 64 BCLK = 256 clk):
- Push 0xA5C3F0 once, mid-frame → next frame, left slot: sdata bits 1..24 = 1010_0101_1100_0011_1111_0000, bits 0 and 25..31 = 0. Right slot repeats the same word; lrclk rises at bit 32.
- Push 0x800000 → sdata is 1 only at bit_cnt 1 and 33. Push 0x7FFFFF → bit_cnt 1 and 33 are 0, and 2..24 and 34..56 are 1.
- Five back-to-back sample_valid pulses right after reset → fifo_level reads 4, overflow pulses once on the 5th write, and the next four frames carry samples 1..4 in order.
- No pushes after reset → underflow pulses once per frame and sdata stays 0. Then push 0x123456 → it is sent next frame. With no further pushes it is repeated in later frames, and underflow continues to pulse once per frame.
- Assert rst_n low at bit_cnt=40 with 2 samples queued → all outputs are 0 within the same cycle and fifo_level = 0. After release, underflow pulses at the first frame start.
- With SIGMA_DELTA_I2S_LEFT_JUSTIFIED_EN defined, push 0xA5C3F0 → the pattern occupies bits 0..23 of each slot and bits 24..31 are 0.
